// File: rtl/VX_gpu_pkg.sv
// Shared GPU core types and constants.
// Tensor issue arbiter widths, request bundle and drain FSM states.
package VX_gpu_pkg;

  localparam int TENSOR_NUM_REQS    = 4;
  localparam int TENSOR_NUM_WARPS   = 8;
  localparam int TENSOR_WID_W       = $clog2(TENSOR_NUM_WARPS);
  localparam int TENSOR_DATAW       = 64;
  localparam int TENSOR_MAX_CREDITS = 4;
  localparam int TENSOR_CTR_W       = 4;

  typedef struct packed {
    logic [TENSOR_WID_W-1:0] wid;
    logic [TENSOR_DATAW-1:0] data;
  } tensor_req_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } tensor_arb_state_e;

endpackage

// File: rtl/vx_tensor_rr_pick.sv
// Rotating-priority picker: first eligible slot at or after rr_ptr.
// Combinational; returns a one-hot grant plus its index.
module vx_tensor_rr_pick #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] eligible,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vx_tensor_issue_arbiter.sv
// Shares the tensor unit among issue slots with credits,
// per-warp inflight tracking and a drain handshake.
module vx_tensor_issue_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS    = TENSOR_NUM_REQS,
  parameter int NUM_WARPS   = TENSOR_NUM_WARPS,
  parameter int DATAW       = TENSOR_DATAW,
  parameter int MAX_CREDITS = TENSOR_MAX_CREDITS,
  parameter int CTR_W       = TENSOR_CTR_W,
  parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*WID_W-1:0] req_wid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      tc_valid,
  output logic [WID_W-1:0]          tc_wid,
  output logic [DATAW-1:0]          tc_data,
  input  logic                      tc_ready,
  input  logic                      done_valid,
  input  logic [WID_W-1:0]          done_wid,
  output logic [NUM_WARPS-1:0]      warp_idle,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      err_underflow
);

  localparam int CRED_W = $clog2(MAX_CREDITS + 1);
  localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [CTR_W-1:0]  SAT  = '1;
  localparam logic [CRED_W-1:0] CMAX = CRED_W'(MAX_CREDITS);

  tensor_arb_state_e state, state_nxt;
  tensor_req_t       out_q;
  logic              out_v;

  logic [CRED_W-1:0] credits, credits_nxt;
  logic [CTR_W-1:0]  cnt     [NUM_WARPS];
  logic [CTR_W-1:0]  cnt_nxt [NUM_WARPS];
  logic [IDX_W-1:0]  rr_ptr;

  logic [NUM_REQS-1:0] eligible, grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [WID_W-1:0]    g_wid;
  logic [DATAW-1:0]    g_data;
  logic                out_free, done_ok, done_bad;

  // Free slot never looks at tc_ready unless the register holds an op.
  always_comb begin
    out_free = !out_v || tc_ready;
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && (state == RUN)
                 && (credits != '0)
                 && (cnt[req_wid[i*WID_W +: WID_W]] != SAT)
                 && out_free;
    end
  end

  vx_tensor_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .IDX_W    (IDX_W)
  ) rr_pick (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign g_wid    = req_wid[grant_idx*WID_W +: WID_W];
  assign g_data   = req_data[grant_idx*DATAW +: DATAW];
  assign done_ok  = done_valid && (cnt[done_wid] != '0);
  assign done_bad = done_valid && (cnt[done_wid] == '0);

  always_comb begin
    credits_nxt = credits;
    if (grant_valid && !done_ok)
      credits_nxt = credits - 1'b1;
    else if (!grant_valid && done_ok && credits != CMAX)
      credits_nxt = credits + 1'b1;
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      cnt_nxt[w] = cnt[w];
      if (grant_valid && g_wid == WID_W'(w)
          && !(done_ok && done_wid == WID_W'(w)))
        cnt_nxt[w] = cnt[w] + 1'b1;
      else if (done_ok && done_wid == WID_W'(w)
          && !(grant_valid && g_wid == WID_W'(w)))
        cnt_nxt[w] = cnt[w] - 1'b1;
    end
  end

  // Drain exits on the returning credit, so DONE follows the last done by one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (credits_nxt == CMAX && !out_v) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      credits       <= CMAX;
      rr_ptr        <= '0;
      out_v         <= 1'b0;
      out_q         <= '0;
      err_underflow <= 1'b0;
      warp_idle     <= '1;
      for (int w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
    end else begin
      state   <= state_nxt;
      credits <= credits_nxt;
      for (int w = 0; w < NUM_WARPS; w++) begin
        cnt[w]       <= cnt_nxt[w];
        warp_idle[w] <= (cnt_nxt[w] == '0);
      end
      if (done_bad) err_underflow <= 1'b1;
      if (grant_valid) begin
        out_v      <= 1'b1;
        out_q.wid  <= g_wid;
        out_q.data <= g_data;
        rr_ptr     <= (grant_idx == IDX_W'(NUM_REQS - 1))
                      ? '0 : grant_idx + 1'b1;
      end else if (tc_ready) begin
        out_v <= 1'b0;
      end
    end
  end

  assign req_ready  = grant;
  assign tc_valid   = out_v;
  assign tc_wid     = out_q.wid;
  assign tc_data    = out_q.data;
  assign drain_done = (state == DONE);

endmodule

// File: tb/tb_vx_tensor_issue_arbiter.sv
// Directed bench for the tensor issue arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_vx_tensor_issue_arbiter;
  import VX_gpu_pkg::*;

  localparam int NR = 4;
  localparam int NW = 8;
  localparam int WW = 3;
  localparam int DW = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*WW-1:0] req_wid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           tc_valid;
  logic [WW-1:0]  tc_wid;
  logic [DW-1:0]  tc_data;
  logic           tc_ready = 1'b0;
  logic           done_valid = 1'b0;
  logic [WW-1:0]  done_wid = '0;
  logic [NW-1:0]  warp_idle;
  logic           drain_req = 1'b0;
  logic           drain_done;
  logic           err_underflow;

  int passed = 0;
  int total  = 0;

  vx_tensor_issue_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_wid       (req_wid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tc_valid      (tc_valid),
    .tc_wid        (tc_wid),
    .tc_data       (tc_data),
    .tc_ready      (tc_ready),
    .done_valid    (done_valid),
    .done_wid      (done_wid),
    .warp_idle     (warp_idle),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic [WW-1:0] w,
                         input logic [DW-1:0] d);
    req_wid[s*WW +: WW]  = w;
    req_data[s*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    tc_ready   = 1'b0;
    done_valid = 1'b0;
    drain_req  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (tc_valid !== 1'b0) $display("FAIL rst_tc_valid got=%b exp=0", tc_valid); else passed++;
    total++; if (warp_idle !== 8'hff) $display("FAIL rst_idle got=%h exp=ff", warp_idle); else passed++;
    total++; if (drain_done !== 1'b0) $display("FAIL rst_drain_done got=%b exp=0", drain_done); else passed++;
    total++; if (err_underflow !== 1'b0) $display("FAIL rst_err got=%b exp=0", err_underflow); else passed++;
    total++; if (req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0", req_ready); else passed++;
    total++; if (dut.credits !== 3'd4) $display("FAIL rst_credits got=%0d exp=4", dut.credits); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    tc_ready  = 1'b1;
    set_req(0, 3'd2, 64'hA5A5_0000_1234_5678);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else passed++;
    tick();
    req_valid = '0;
    #1;
    total++; if (tc_valid !== 1'b1) $display("FAIL single_tc_valid got=%b exp=1", tc_valid); else passed++;
    total++; if (tc_wid !== 3'd2) $display("FAIL single_wid got=%0d exp=2", tc_wid); else passed++;
    total++; if (tc_data !== 64'hA5A5_0000_1234_5678) $display("FAIL single_data got=%h exp=a5a5000012345678", tc_data); else passed++;
    total++; if (warp_idle !== 8'hfb) $display("FAIL single_idle_busy got=%h exp=fb", warp_idle); else passed++;
    total++; if (dut.credits !== 3'd3) $display("FAIL single_credits got=%0d exp=3", dut.credits); else passed++;
    tick();
    #1;
    total++; if (tc_valid !== 1'b0) $display("FAIL single_drained got=%b exp=0", tc_valid); else passed++;
    done_valid = 1'b1;
    done_wid   = 3'd2;
    tick();
    done_valid = 1'b0;
    #1;
    total++; if (warp_idle !== 8'hff) $display("FAIL single_idle_back got=%h exp=ff", warp_idle); else passed++;
    total++; if (dut.credits !== 3'd4) $display("FAIL single_credits_back got=%0d exp=4", dut.credits); else passed++;
    total++; if (err_underflow !== 1'b0) $display("FAIL single_err got=%b exp=0", err_underflow); else passed++;
  endtask

  task automatic test_rotate();
    logic [NR-1:0] exp_g;
    do_reset();
    tc_ready = 1'b1;
    for (int s = 0; s < NR; s++) set_req(s, WW'(s), DW'(64'h100 + s));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      done_valid = (k > 0);
      done_wid   = WW'((k + 3) % 4);
      exp_g      = 4'b0001 << (k % 4);
      #1;
      total++; if (req_ready !== exp_g) $display("FAIL rot_grant%0d got=%b exp=%b", k, req_ready, exp_g); else passed++;
      tick();
      total++; if (tc_wid !== WW'(k % 4)) $display("FAIL rot_wid%0d got=%0d exp=%0d", k, tc_wid, k % 4); else passed++;
    end
    req_valid  = '0;
    done_valid = 1'b1;
    done_wid   = 3'd0;
    tick();
    done_valid = 1'b0;
    #1;
    total++; if (dut.credits !== 3'd4) $display("FAIL rot_credits got=%0d exp=4", dut.credits); else passed++;
    total++; if (warp_idle !== 8'hff) $display("FAIL rot_idle got=%h exp=ff", warp_idle); else passed++;
    total++; if (err_underflow !== 1'b0) $display("FAIL rot_err got=%b exp=0", err_underflow); else passed++;
  endtask

  task automatic test_credits();
    do_reset();
    tc_ready = 1'b1;
    set_req(0, 3'd4, 64'h44);
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (req_ready !== 4'b0001) $display("FAIL cred_grant%0d got=%b exp=0001", k, req_ready); else passed++;
      tick();
    end
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL cred_block0 got=%b exp=0000", req_ready); else passed++;
    tick();
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL cred_block1 got=%b exp=0000", req_ready); else passed++;
    done_valid = 1'b1;
    done_wid   = 3'd4;
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL cred_done_cycle got=%b exp=0000", req_ready); else passed++;
    tick();
    done_valid = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL cred_regrant got=%b exp=0001", req_ready); else passed++;
    tick();
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL cred_only_one got=%b exp=0000", req_ready); else passed++;
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    tc_ready = 1'b0;
    set_req(0, 3'd1, 64'hAAAA_AAAA_0000_0001);
    set_req(1, 3'd3, 64'hBBBB_BBBB_0000_0002);
    req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL bp_first got=%b exp=0001", req_ready); else passed++;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (tc_valid !== 1'b1) $display("FAIL bp_valid%0d got=%b exp=1", k, tc_valid); else passed++;
      total++; if (tc_wid !== 3'd1) $display("FAIL bp_wid%0d got=%0d exp=1", k, tc_wid); else passed++;
      total++; if (tc_data !== 64'hAAAA_AAAA_0000_0001) $display("FAIL bp_data%0d got=%h exp=aaaaaaaa00000001", k, tc_data); else passed++;
      total++; if (req_ready !== 4'b0000) $display("FAIL bp_nogrant%0d got=%b exp=0000", k, req_ready); else passed++;
      tick();
    end
    tc_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL bp_b2b got=%b exp=0010", req_ready); else passed++;
    tick();
    req_valid = '0;
    #1;
    total++; if (tc_valid !== 1'b1) $display("FAIL bp_next_valid got=%b exp=1", tc_valid); else passed++;
    total++; if (tc_wid !== 3'd3) $display("FAIL bp_next_wid got=%0d exp=3", tc_wid); else passed++;
    total++; if (tc_data !== 64'hBBBB_BBBB_0000_0002) $display("FAIL bp_next_data got=%h exp=bbbbbbbb00000002", tc_data); else passed++;
  endtask

  task automatic test_drain();
    do_reset();
    tc_ready = 1'b1;
    set_req(0, 3'd6, 64'h66);
    req_valid = 4'b0001;
    tick();
    tick();
    tick();
    req_valid = '0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL drn_block got=%b exp=0000", req_ready); else passed++;
    total++; if (drain_done !== 1'b0) $display("FAIL drn_early got=%b exp=0", drain_done); else passed++;
    for (int j = 0; j < 3; j++) begin
      done_valid = 1'b1;
      done_wid   = 3'd6;
      #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL drn_block%0d got=%b exp=0000", j, req_ready); else passed++;
      total++; if (drain_done !== 1'b0) $display("FAIL drn_done_early%0d got=%b exp=0", j, drain_done); else passed++;
      tick();
    end
    done_valid = 1'b0;
    #1;
    total++; if (drain_done !== 1'b1) $display("FAIL drn_pulse got=%b exp=1", drain_done); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL drn_pulse_block got=%b exp=0000", req_ready); else passed++;
    tick();
    #1;
    total++; if (drain_done !== 1'b0) $display("FAIL drn_one_cycle got=%b exp=0", drain_done); else passed++;
    total++; if (req_ready !== 4'b0001) $display("FAIL drn_resume got=%b exp=0001", req_ready); else passed++;
    tick();
    req_valid = '0;
    #1;
    total++; if (tc_valid !== 1'b1) $display("FAIL drn_resume_valid got=%b exp=1", tc_valid); else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    done_valid = 1'b1;
    done_wid   = 3'd5;
    tick();
    done_valid = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b1) $display("FAIL uf_err got=%b exp=1", err_underflow); else passed++;
    total++; if (dut.credits !== 3'd4) $display("FAIL uf_credits got=%0d exp=4", dut.credits); else passed++;
    total++; if (warp_idle !== 8'hff) $display("FAIL uf_idle got=%h exp=ff", warp_idle); else passed++;
    tick();
    #1;
    total++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky got=%b exp=1", err_underflow); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    tc_ready = 1'b1;
    set_req(0, 3'd1, 64'h11);
    req_valid = 4'b0001;
    tick();
    done_valid = 1'b1;
    done_wid   = 3'd1;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL sc_grant got=%b exp=0001", req_ready); else passed++;
    tick();
    req_valid  = '0;
    done_valid = 1'b0;
    #1;
    total++; if (dut.cnt[1] !== 4'd1) $display("FAIL sc_cnt got=%0d exp=1", dut.cnt[1]); else passed++;
    total++; if (dut.credits !== 3'd3) $display("FAIL sc_credits got=%0d exp=3", dut.credits); else passed++;
    total++; if (warp_idle !== 8'hfd) $display("FAIL sc_idle got=%h exp=fd", warp_idle); else passed++;
    total++; if (err_underflow !== 1'b0) $display("FAIL sc_err got=%b exp=0", err_underflow); else passed++;
    done_valid = 1'b1;
    tick();
    done_valid = 1'b0;
    #1;
    total++; if (warp_idle !== 8'hff) $display("FAIL sc_idle_back got=%h exp=ff", warp_idle); else passed++;
    total++; if (dut.credits !== 3'd4) $display("FAIL sc_credits_back got=%0d exp=4", dut.credits); else passed++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    tc_ready = 1'b1;
    set_req(0, 3'd2, 64'h22);
    set_req(1, 3'd7, 64'h77);
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    total++; if (dut.state !== DRAIN) $display("FAIL rmd_in_drain got=%0d exp=%0d", dut.state, DRAIN); else passed++;
    total++; if (warp_idle !== 8'h7b) $display("FAIL rmd_idle_busy got=%h exp=7b", warp_idle); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (dut.state !== RUN) $display("FAIL rmd_state got=%0d exp=%0d", dut.state, RUN); else passed++;
    total++; if (dut.credits !== 3'd4) $display("FAIL rmd_credits got=%0d exp=4", dut.credits); else passed++;
    total++; if (warp_idle !== 8'hff) $display("FAIL rmd_idle got=%h exp=ff", warp_idle); else passed++;
    total++; if (tc_valid !== 1'b0) $display("FAIL rmd_tc_valid got=%b exp=0", tc_valid); else passed++;
    done_valid = 1'b1;
    done_wid   = 3'd2;
    tick();
    done_valid = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b1) $display("FAIL rmd_stale_done got=%b exp=1", err_underflow); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_credits();
    test_back_to_back();
    test_drain();
    test_underflow();
    test_same_cycle();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
